// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, action encoding and priority decode for pipeline stage registers
package pipe_pkg;
   localparam int STALL_UP = 0;
   localparam int STALL_DN = 1;
   localparam int PERF_W   = 32;
   typedef enum logic [1:0] {ACT_LOAD, ACT_BUBBLE, ACT_HOLD, ACT_FLUSH} pipe_act_t;
   function automatic pipe_act_t pipe_decode(input logic flush, input logic [1:0] stall);
      return flush ? ACT_FLUSH : stall[STALL_DN] ? ACT_HOLD : stall[STALL_UP] ? ACT_BUBBLE : ACT_LOAD;
   endfunction
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: up-counter that sticks at MAX, with synchronous clear taking priority over increment
module pipe_sat_counter #(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);
   // count up until MAX, clear wins over increment
   always_ff @(posedge CLK or negedge RST)
      if (!RST) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && cnt != MAX) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-lane inter-stage register with flush/hold/bubble priority and hold watchdog.
// Performance counters are built only when PIPE_REG_PERF_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                LANES      = 1,
   parameter logic [DATA_W-1:0] NOP_WORD   = '0,
   parameter int                HOLD_LIMIT = 15
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [1:0]              STALL,
   input  logic                    FLUSH,
   input  logic [LANES-1:0]        IN_VALID,
   input  logic [LANES*DATA_W-1:0] IN_DATA,
   output logic [LANES-1:0]        OUT_VALID,
   output logic [LANES*DATA_W-1:0] OUT_DATA,
   output logic                    HOLD_TIMEOUT,
   input  logic                    PERF_CLR,
   output logic [31:0]             PERF_LOAD_CNT,
   output logic [31:0]             PERF_BUBBLE_CNT
);
   localparam int              HW   = $clog2(HOLD_LIMIT + 1);
   localparam logic [HW-1:0]   HMAX = HW'(HOLD_LIMIT);
   pipe_act_t                  act;
   logic [LANES*DATA_W-1:0]    load_data;
   logic [HW-1:0]              hold_cnt;
   // pick the single action for this cycle and squash invalid lanes to the bubble word
   always_comb begin
      act = pipe_decode(FLUSH, STALL);
      for (int i = 0; i < LANES; i++)
         load_data[i*DATA_W +: DATA_W] = IN_VALID[i] ? IN_DATA[i*DATA_W +: DATA_W] : NOP_WORD;
   end
   // payload and valid register; hold keeps the current contents
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         OUT_VALID <= '0;
         OUT_DATA  <= {LANES{NOP_WORD}};
      end else if (act == ACT_FLUSH || act == ACT_BUBBLE) begin
         OUT_VALID <= '0;
         OUT_DATA  <= {LANES{NOP_WORD}};
      end else if (act == ACT_LOAD) begin
         OUT_VALID <= IN_VALID;
         OUT_DATA  <= load_data;
      end
   pipe_sat_counter #(.W(HW), .MAX(HMAX)) u_hold (
      .CLK(CLK), .RST(RST), .inc(act == ACT_HOLD), .clr(act != ACT_HOLD), .cnt(hold_cnt)
   );
   assign HOLD_TIMEOUT = (hold_cnt == HMAX);
`ifdef PIPE_REG_PERF_EN
   pipe_sat_counter #(.W(PERF_W)) u_perf_load (
      .CLK(CLK), .RST(RST), .inc(act == ACT_LOAD && |IN_VALID), .clr(PERF_CLR), .cnt(PERF_LOAD_CNT)
   );
   pipe_sat_counter #(.W(PERF_W)) u_perf_bubble (
      .CLK(CLK), .RST(RST), .inc(act == ACT_BUBBLE || act == ACT_FLUSH), .clr(PERF_CLR),
      .cnt(PERF_BUBBLE_CNT)
   );
`else
   logic perf_clr_unused;
   assign perf_clr_unused = PERF_CLR;
   assign PERF_LOAD_CNT   = '0;
   assign PERF_BUBBLE_CNT = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg (2 lanes, HOLD_LIMIT=4)
module tb_pipe_stage_reg;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          LIM = 4;
   logic        CLK = 0;
   logic        RST = 0;
   logic [1:0]  STALL = '0;
   logic        FLUSH = 0;
   logic [1:0]  IN_VALID = '0;
   logic [63:0] IN_DATA = '0;
   logic [1:0]  OUT_VALID;
   logic [63:0] OUT_DATA;
   logic        HOLD_TIMEOUT;
   logic        PERF_CLR = 0;
   logic [31:0] PERF_LOAD_CNT, PERF_BUBBLE_CNT;
   int errors = 0;
   int checks = 0;
   logic [1:0]  mv;
   logic [63:0] md;
   int          mh, mpl, mpb;
   typedef struct {
      string       tag;
      logic [1:0]  v;
      logic [63:0] d;
      logic        to;
      logic [31:0] pl, pb;
   } exp_t;
   exp_t sb[$];

   pipe_stage_reg #(.DATA_W(32), .LANES(2), .NOP_WORD(NOP), .HOLD_LIMIT(LIM)) dut (
      .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .HOLD_TIMEOUT(HOLD_TIMEOUT), .PERF_CLR(PERF_CLR),
      .PERF_LOAD_CNT(PERF_LOAD_CNT), .PERF_BUBBLE_CNT(PERF_BUBBLE_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mv = '0; md = {NOP, NOP}; mh = 0; mpl = 0; mpb = 0;
   endtask

   task automatic check_all(input exp_t e);
      chk({e.tag, ".valid"}, 64'(OUT_VALID), 64'(e.v));
      chk({e.tag, ".data"}, OUT_DATA, e.d);
      chk({e.tag, ".timeout"}, 64'(HOLD_TIMEOUT), 64'(e.to));
      chk({e.tag, ".perf_load"}, 64'(PERF_LOAD_CNT), 64'(e.pl));
      chk({e.tag, ".perf_bubble"}, 64'(PERF_BUBBLE_CNT), 64'(e.pb));
   endtask

   function automatic exp_t snap(input string tag);
      exp_t e;
      e.tag = tag; e.v = mv; e.d = md; e.to = (mh == LIM);
`ifdef PIPE_REG_PERF_EN
      e.pl = 32'(mpl); e.pb = 32'(mpb);
`else
      e.pl = '0; e.pb = '0;
`endif
      return e;
   endfunction

   task automatic step(input string tag, input logic [1:0] st, input logic fl, input logic [1:0] iv,
                       input logic [63:0] id, input logic pc);
      exp_t e;
      STALL = st; FLUSH = fl; IN_VALID = iv; IN_DATA = id; PERF_CLR = pc;
      if (fl || (!st[1] && st[0])) begin
         mv = '0; md = {NOP, NOP}; mh = 0; mpb++;
      end else if (st[1]) begin
         mh = (mh < LIM) ? mh + 1 : LIM;
      end else begin
         mv = iv;
         md = {iv[1] ? id[63:32] : NOP, iv[0] ? id[31:0] : NOP};
         mh = 0;
         if (iv != 2'b00) mpl++;
      end
      if (pc) begin mpl = 0; mpb = 0; end
      sb.push_back(snap(tag));
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      check_all(e);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check_all(snap("reset"));
      @(negedge CLK);
      RST = 1;
      step("load1", 2'b00, 0, 2'b01, {32'h0, 32'h1234_5678}, 0);
      step("loadA", 2'b00, 0, 2'b11, {32'h5555_0001, 32'hAAAA_0001}, 0);
      for (int i = 0; i < 3; i++)
         step("hold", 2'b10, 0, 2'b11, {32'h9000_0000 + i, 32'h7000_0000 + i}, 0);
      step("hold11", 2'b11, 0, 2'b11, {32'h1, 32'h2}, 0);
      step("bubble", 2'b01, 0, 2'b11, {32'h3, 32'h4}, 0);
      step("loadB", 2'b00, 0, 2'b01, {32'h0, 32'hCAFE_0001}, 0);
      step("hold_pre", 2'b10, 0, 2'b01, {32'h0, 32'h5}, 0);
      step("hold_pre", 2'b10, 0, 2'b01, {32'h0, 32'h6}, 0);
      step("flush_hold", 2'b10, 1, 2'b11, {32'h7, 32'h8}, 0);
      for (int i = 0; i < 3; i++)
         step("hold_postflush", 2'b10, 0, 2'b11, {32'h9, 32'hA}, 0);
      step("loadC", 2'b00, 0, 2'b11, {32'h2222_0002, 32'h1111_0001}, 0);
      for (int i = 0; i < 6; i++)
         step("wdog", 2'b10, 0, 2'b00, {32'hB, 32'hC}, 0);
      step("wdog_release", 2'b00, 0, 2'b01, {32'h0, 32'h0D0D_0D0D}, 0);
      step("lanes", 2'b00, 0, 2'b10, {32'hBEEF_0002, 32'hDEAD_0001}, 0);
      step("perf_clr0", 2'b00, 0, 2'b11, {32'h1, 32'h2}, 1);
      for (int i = 0; i < 5; i++)
         step("perf_load", 2'b00, 0, 2'b01, {32'h0, 32'h100 + i}, 0);
      step("perf_idle_load", 2'b00, 0, 2'b00, {32'hE, 32'hF}, 0);
      step("perf_bub", 2'b01, 0, 2'b11, {32'h0, 32'h0}, 0);
      step("perf_bub", 2'b01, 0, 2'b11, {32'h0, 32'h0}, 0);
      step("perf_flush", 2'b00, 1, 2'b11, {32'h0, 32'h0}, 0);
      step("perf_clr", 2'b00, 0, 2'b01, {32'h0, 32'h55}, 1);
      step("perf_after", 2'b01, 0, 2'b00, {32'h0, 32'h0}, 0);
      step("pre_rst", 2'b00, 0, 2'b11, {32'h6666_0006, 32'h7777_0007}, 0);
      for (int i = 0; i < 5; i++)
         step("hold_rst", 2'b10, 0, 2'b11, {32'h0, 32'h0}, 0);
      #2 RST = 0;
      #1;
      model_reset();
      check_all(snap("async_rst"));
      @(negedge CLK);
      RST = 1;
      step("post_rst_hold", 2'b10, 0, 2'b11, {32'h1, 32'h2}, 0);
      step("post_rst_load", 2'b00, 0, 2'b11, {32'h8888_0008, 32'h9999_0009}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register that generalises the single-purpose ID/EX register into a reusable block. It can be placed between any two adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries LANES independent payload lanes, each with its own valid bit. It resolves stall and flush with a fixed priority, inserting bubbles or holding as required. It also reports prolonged holds through a watchdog and, optionally, through performance counters.

## Interface
Parameters:
- DATA_W, 32: payload width per lane in bits.
- LANES, 1: number of parallel lanes (issue width).
- NOP_WORD, '0: DATA_W-bit value that represents a bubble payload.
- HOLD_LIMIT, 15: number of consecutive hold cycles after which HOLD_TIMEOUT asserts. Must be ≥1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- STALL  in  2  [0] = upstream stage stopped, [1] = downstream stage stopped.
- FLUSH  in  1  synchronous kill of the register contents.
- IN_VALID  in  LANES  per-lane valid from the upstream stage.
- IN_DATA  in  LANES*DATA_W  upstream payload; lane i occupies bits [i*DATA_W +: DATA_W].
- OUT_VALID  out  LANES  per-lane valid to the downstream stage.
- OUT_DATA  out  LANES*DATA_W  registered payload.
- HOLD_TIMEOUT  out  1  held for HOLD_LIMIT or more consecutive cycles.
- PERF_CLR  in  1  synchronous clear of the performance counters.
- PERF_LOAD_CNT  out  32  count of load cycles.
- PERF_BUBBLE_CNT  out  32  count of bubble-insertion cycles.

## Operation
- Reset (RST=0, asynchronous):
  - OUT_VALID=0.
  - Every OUT_DATA lane = NOP_WORD.
  - Hold counter = 0, HOLD_TIMEOUT=0.
  - Performance counters = 0.
- Each cycle exactly one action is taken, chosen by priority:
  - FLUSH: FLUSH=1. All OUT_VALID bits = 0 and every lane = NOP_WORD, regardless of STALL.
  - HOLD: STALL[1]=1. Outputs are unchanged, regardless of STALL[0].
  - BUBBLE: STALL[0]=1 and STALL[1]=0. Same register effect as FLUSH.
  - LOAD: STALL=2'b00. For each lane i, OUT_VALID[i] <= IN_VALID[i]. OUT_DATA lane i <= IN_DATA lane i if IN_VALID[i]=1, otherwise NOP_WORD.
- The HOLD rule closes a gap in the previous block: with STALL=2'b10 it loaded new data; this block holds.
- Hold counter:
  - Increments on each HOLD cycle and saturates at HOLD_LIMIT.
  - Clears to 0 on any other action.
  - Width is $clog2(HOLD_LIMIT+1).
- HOLD_TIMEOUT is registered and equals (hold counter == HOLD_LIMIT).
- STALL=2'b11 is a HOLD; upstream stall is irrelevant while downstream is stalled.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- There is no combinational path from any input to any output.
- HOLD_TIMEOUT first asserts after the edge that completes the HOLD_LIMIT-th consecutive HOLD cycle.
  - It deasserts after the first non-HOLD edge.
- A FLUSH coincident with STALL[1]=1 flushes, and the hold counter clears that same edge.
- Reset mid-hold clears all state immediately (asynchronous); the first edge after reset release performs its normal action.
- PERF_CLR has priority over the increment in the same cycle: the counter reads 0 after that edge.

## Configuration
- PIPE_REG_PERF_EN defined:
  - PERF_LOAD_CNT increments on each LOAD cycle in which at least one IN_VALID bit is 1.
  - PERF_BUBBLE_CNT increments on each BUBBLE or FLUSH cycle.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and clear on PERF_CLR.
- PIPE_REG_PERF_EN undefined:
  - The counters and their logic are omitted.
  - PERF_LOAD_CNT and PERF_BUBBLE_CNT are driven to constant 0; PERF_CLR is ignored.
  - The port list is identical in both builds.

## Structure
- Shared package pipe_pkg:
  - Constants STALL_UP=0 and STALL_DN=1.
  - Enum pipe_act_t {ACT_LOAD, ACT_BUBBLE, ACT_HOLD, ACT_FLUSH}, produced by a combinational priority decode.
  - PERF_W=32.
- One sub-module, pipe_sat_counter (parameter W; inputs inc and clr; output cnt):
  - Used for the hold counter and both performance counters.

## Test plan
- Reset release, then STALL=00, IN_VALID=1, IN_DATA=32'h1234_5678 → after one edge OUT_VALID=1, OUT_DATA=32'h1234_5678, HOLD_TIMEOUT=0.
- Load 32'hAAAA_0001, then STALL=10 for 3 cycles while IN_DATA changes → OUT_DATA stays 32'hAAAA_0001 and OUT_VALID stays 1. Then STALL=01 → OUT_VALID=0, OUT_DATA=NOP_WORD.
- Load a value, then STALL=10 with FLUSH=1 → after one edge OUT_VALID=0, OUT_DATA=NOP_WORD, hold counter=0.
- HOLD_LIMIT=4, STALL=10 for 6 cycles → HOLD_TIMEOUT=0 for the first 3 edges, 1 from edge 4 through edge 6. Then STALL=00 → 0 after the next edge.
- LANES=2, IN_VALID=2'b10, lanes = {32'hBEEF_0002, 32'hDEAD_0001}, STALL=00 → OUT_VALID=2'b10, lane1=32'hBEEF_0002, lane0=NOP_WORD.
- With PIPE_REG_PERF_EN: 5 LOAD (valid) cycles, 2 BUBBLE, 1 FLUSH → PERF_LOAD_CNT=5, PERF_BUBBLE_CNT=3. Then PERF_CLR=1 → both 0. Without the macro both read 0 throughout.
